// File: rtl/seg_display_ctrl_if.sv
// CPU IO-bus port of the seven-segment display controller: chip select,
// write strobe, register select, write data and the conversion busy flag.
interface seg_display_ctrl_if;
  logic        digcs;
  logic        digwrite;
  logic [1:0]  digaddr;
  logic [31:0] write_data;
  logic        busy;

  modport master (
    output digcs,
    output digwrite,
    output digaddr,
    output write_data,
    input  busy
  );

  modport slave (
    input  digcs,
    input  digwrite,
    input  digaddr,
    input  write_data,
    output busy
  );
endinterface

// File: rtl/seg_display_ctrl.sv
// Memory-mapped seven-segment display controller. VALUE is shown either as
// hex nibbles or, in decimal mode, through a sequential double-dabble
// converter. Digits are multiplexed one at a time with leading-zero blanking,
// per-digit enable and per-digit blink. DIG and Y are active-low.
module seg_display_ctrl #(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 20000,
  parameter int BLINK_DIV = 64
) (
  input  logic              clk,
  input  logic              rst,
  seg_display_ctrl_if.slave bus,
  output logic [DIGITS-1:0] DIG,
  output logic [7:0]        Y
);

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int BUF_W   = 4 * DIGITS;
  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [7:0] SEG_OFF  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  genvar gi;

  // CPU-visible registers
  logic [31:0]        value_reg;
  logic               mode_reg;
  logic               lzb_reg;
  logic [DIGITS-1:0]  enable_reg;
  logic [DIGITS-1:0]  blink_reg;

  // conversion FSM and display buffer
  state_t             state_reg, state_next;
  logic               start_pend_reg, start_pend_next;
  logic [31:0]        bin_reg, bin_next;
  logic [39:0]        bcd_reg, bcd_next;
  logic [39:0]        bcd_adj;
  logic [4:0]         bit_cnt_reg, bit_cnt_next;
  logic [BUF_W-1:0]   buf_reg, buf_next;
  logic               dash_reg, dash_next;
  logic               overflow;

  // scan timing
  logic [SCAN_W-1:0]  scan_cnt_reg;
  logic [2:0]         index_reg;
  logic [BLINK_W-1:0] blink_cnt_reg;
  logic               phase_reg;

  // digit selection and segment output
  logic [DIGITS-1:0]  nz;
  logic [DIGITS-1:0]  tail_zero;
  logic [DIGITS-1:0]  lit_vec;
  logic [3:0]         cur_nib;
  logic [DIGITS-1:0]  dig_reg;
  logic [7:0]         y_reg;

  // write decode
  logic wr_en, wr_value, wr_ctrl, new_mode, start_req, abort_req;
  logic unused_ok;

  assign wr_en     = bus.digcs & bus.digwrite;
  assign wr_value  = wr_en & (bus.digaddr == 2'd0);
  assign wr_ctrl   = wr_en & (bus.digaddr == 2'd1);
  // MODE as it will be after this write
  assign new_mode  = wr_ctrl ? bus.write_data[0] : mode_reg;
  assign start_req = (wr_value | wr_ctrl) & new_mode;
  assign abort_req = wr_ctrl & ~bus.write_data[0];

  assign unused_ok = ^{bus.write_data, bcd_adj[39], tail_zero[0]};

  function automatic logic [7:0] seg7(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'h0:    code = 8'hC0;
      4'h1:    code = 8'hF9;
      4'h2:    code = 8'hA4;
      4'h3:    code = 8'hB0;
      4'h4:    code = 8'h99;
      4'h5:    code = 8'h92;
      4'h6:    code = 8'h82;
      4'h7:    code = 8'hF8;
      4'h8:    code = 8'h80;
      4'h9:    code = 8'h90;
      4'hA:    code = 8'h88;
      4'hB:    code = 8'h83;
      4'hC:    code = 8'hC6;
      4'hD:    code = 8'hA1;
      4'hE:    code = 8'h86;
      default: code = 8'h8E;
    endcase
    return code;
  endfunction

  // Register file: latch VALUE and CTRL writes; addr2/addr3 are ignored
  always_ff @(posedge clk) begin
    if (!rst) begin
      value_reg  <= '0;
      mode_reg   <= 1'b0;
      lzb_reg    <= 1'b0;
      enable_reg <= '1;
      blink_reg  <= '0;
    end else begin
      if (wr_value) begin
        value_reg <= bus.write_data;
      end
      if (wr_ctrl) begin
        mode_reg   <= bus.write_data[0];
        lzb_reg    <= bus.write_data[1];
        enable_reg <= bus.write_data[8 +: DIGITS];
        blink_reg  <= bus.write_data[16 +: DIGITS];
      end
    end
  end

  // Add-3 correction of every BCD nibble ahead of the shift
  for (gi = 0; gi < 10; gi++) begin : g_dabble
    assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
  end

  // Any BCD digit beyond the display width means VALUE >= 10^DIGITS
  assign overflow = |bcd_reg[39:BUF_W];

  // Conversion FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      start_pend_reg <= 1'b0;
      bin_reg        <= '0;
      bcd_reg        <= '0;
      bit_cnt_reg    <= '0;
      buf_reg        <= '0;
      dash_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      start_pend_reg <= start_pend_next;
      bin_reg        <= bin_next;
      bcd_reg        <= bcd_next;
      bit_cnt_reg    <= bit_cnt_next;
      buf_reg        <= buf_next;
      dash_reg       <= dash_next;
    end
  end

  // Conversion FSM next state: a start write is remembered for one cycle and
  // (re)loads CONV on the following edge; the buffer only changes in DONE
  always_comb begin
    state_next      = state_reg;
    start_pend_next = start_req;
    bin_next        = bin_reg;
    bcd_next        = bcd_reg;
    bit_cnt_next    = bit_cnt_reg;
    buf_next        = buf_reg;
    dash_next       = dash_reg;
    if (abort_req) begin
      state_next      = IDLE;
      start_pend_next = 1'b0;
    end else if (start_pend_reg) begin
      state_next   = CONV;
      bin_next     = value_reg;
      bcd_next     = '0;
      bit_cnt_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!mode_reg) begin
            buf_next  = value_reg[BUF_W-1:0];
            dash_next = 1'b0;
          end
        end
        CONV: begin
          bin_next     = {bin_reg[30:0], 1'b0};
          bcd_next     = {bcd_adj[38:0], bin_reg[31]};
          bit_cnt_next = bit_cnt_reg + 5'd1;
          if (bit_cnt_reg == 5'd31) begin
            state_next = DONE;
          end
        end
        DONE: begin
          // a write landing here restarts instead of publishing a stale result
          if (start_req) begin
            state_next = CONV;
          end else begin
            state_next = IDLE;
            buf_next   = bcd_reg[BUF_W-1:0];
            dash_next  = overflow;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign bus.busy = (state_reg != IDLE);

  // Scan timing: digit dwell counter, digit index, blink round counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_cnt_reg  <= '0;
      index_reg     <= '0;
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
    end else if (scan_cnt_reg == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_reg <= '0;
      if (index_reg == 3'(DIGITS - 1)) begin
        index_reg <= '0;
        if (blink_cnt_reg == BLINK_W'(BLINK_DIV - 1)) begin
          blink_cnt_reg <= '0;
          phase_reg     <= ~phase_reg;
        end else begin
          blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
      end else begin
        index_reg <= index_reg + 3'd1;
      end
    end else begin
      scan_cnt_reg <= scan_cnt_reg + 1'b1;
    end
  end

  // tail_zero[i]: buffer digits i..DIGITS-1 are all zero
  always_comb begin
    logic acc;
    acc       = 1'b1;
    tail_zero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc          = acc & ~nz[i];
      tail_zero[i] = acc;
    end
  end

  // Per-digit lit decision; dashes count as non-zero so they never blank
  for (gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic lzb_blank;
    assign nz[gi] = dash_reg | (|buf_reg[4*gi +: 4]);
    if (gi == 0) begin : g_first
      assign lzb_blank = 1'b0;
    end else begin : g_rest
      assign lzb_blank = lzb_reg & tail_zero[gi];
    end
    assign lit_vec[gi] = (index_reg == 3'(gi)) & enable_reg[gi] &
                         ~(blink_reg[gi] & phase_reg) & ~lzb_blank;
  end

  // Select the buffer nibble of the digit currently being scanned
  always_comb begin
    cur_nib = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (index_reg == 3'(i)) begin
        cur_nib = buf_reg[4*i +: 4];
      end
    end
  end

  // Registered digit select and segments, updated together
  always_ff @(posedge clk) begin
    if (!rst) begin
      dig_reg <= '1;
      y_reg   <= SEG_OFF;
    end else if (|lit_vec) begin
      dig_reg <= ~lit_vec;
      y_reg   <= dash_reg ? SEG_DASH : seg7(cur_nib);
    end else begin
      dig_reg <= '1;
      y_reg   <= SEG_OFF;
    end
  end

  assign DIG = dig_reg;
  assign Y   = y_reg;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl: expected per-digit segment codes
// are pushed to a scoreboard queue when a write is issued and popped when a
// full scan round has been observed on DIG/Y.
`timescale 1ns/1ps
module tb_seg_display_ctrl;

  localparam int SCAN = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seg_display_ctrl_if bus_a ();
  seg_display_ctrl_if bus_b ();

  logic [7:0] dig_a;
  logic [7:0] y_a;
  logic [3:0] dig_b;
  logic [7:0] y_b;

  seg_display_ctrl #(.DIGITS(8), .SCAN_DIV(SCAN), .BLINK_DIV(2)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a),
    .DIG (dig_a),
    .Y   (y_a)
  );

  seg_display_ctrl #(.DIGITS(4), .SCAN_DIV(SCAN), .BLINK_DIV(2)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b),
    .DIG (dig_b),
    .Y   (y_b)
  );

  bit         sel_b = 1'b0;
  logic [7:0] dig_obs;
  logic [7:0] y_obs;
  assign dig_obs = sel_b ? {4'hF, dig_b} : dig_a;
  assign y_obs   = sel_b ? y_b : y_a;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] old_codes[8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;  10: return 8'h88; 11: return 8'h83;
      12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  // Reference: code expected on digit i for a full (non-blinking) scan round
  function automatic logic [7:0] model_code(input logic [31:0] value, input bit dec,
                                            input bit lzb, input logic [7:0] en,
                                            input int ndig, input int i);
    longint v, p, lim;
    int     d[8];
    bit     all_zero;
    v   = longint'(value);
    lim = 1;
    for (int k = 0; k < ndig; k++) lim = lim * 10;
    p = 1;
    for (int k = 0; k < 8; k++) begin
      d[k] = dec ? int'((v / p) % 10) : int'(value[4*k +: 4]);
      p    = p * 10;
    end
    if (i >= ndig || !en[i]) return 8'hFF;
    if (dec && v >= lim) return 8'hBF;
    if (lzb && i > 0) begin
      all_zero = 1'b1;
      for (int k = i; k < ndig; k++) if (d[k] != 0) all_zero = 1'b0;
      if (all_zero) return 8'hFF;
    end
    return seg_of(d[i]);
  endfunction

  task automatic expect_display(input logic [31:0] value, input bit dec, input bit lzb,
                                input logic [7:0] en, input int ndig);
    for (int i = 0; i < 8; i++) exp_q.push_back(model_code(value, dec, lzb, en, ndig, i));
  endtask

  // Called right after a negedge; the write happens on the next posedge
  task automatic bus_write(input bit to_b, input logic [1:0] addr, input logic [31:0] data);
    $display("[%0t] write dut=%s addr=%0d data=%08h", $time, to_b ? "b" : "a", addr, data);
    if (to_b) begin
      bus_b.digcs = 1'b1; bus_b.digwrite = 1'b1; bus_b.digaddr = addr; bus_b.write_data = data;
    end else begin
      bus_a.digcs = 1'b1; bus_a.digwrite = 1'b1; bus_a.digaddr = addr; bus_a.write_data = data;
    end
    @(negedge clk);
    bus_a.digcs = 1'b0; bus_a.digwrite = 1'b0;
    bus_b.digcs = 1'b0; bus_b.digwrite = 1'b0;
  endtask

  task automatic check_hold();
    for (int i = 0; i < 8; i++) if (!dig_a[i]) chk("hold_old", y_a, old_codes[i]);
  endtask

  // Count busy cycles starting one cycle after the last write
  task automatic wait_busy(input string tag, input bit hold_chk);
    int n;
    n = 0;
    @(negedge clk);
    while (bus_a.busy && n < 200) begin
      if (hold_chk) check_hold();
      n++;
      @(negedge clk);
    end
    chk(tag, n, 33);
  endtask

  // Observe a bit more than one scan round and compare against the scoreboard
  task automatic capture_round();
    logic [7:0] got[8];
    logic [7:0] dobs;
    int         multi;
    multi = 0;
    for (int i = 0; i < 8; i++) got[i] = 8'hFF;
    repeat (2) @(negedge clk);
    for (int k = 0; k < SCAN * 8 + 8; k++) begin
      @(negedge clk);
      dobs = dig_obs;
      if ($countones(~dobs) > 1) multi++;
      for (int i = 0; i < 8; i++) if (!dobs[i]) got[i] = y_obs;
    end
    chk("dig_onehot", multi, 0);
    for (int i = 0; i < 8; i++) begin
      if (exp_q.size() == 0) chk("sb_empty", 1, 0);
      else chk($sformatf("digit%0d", i), got[i], exp_q.pop_front());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         busy_seen, found, lit0, lit7, y0_bad;
    logic [7:0] prev, rounds0, e;

    bus_a.digcs = 1'b0; bus_a.digwrite = 1'b0; bus_a.digaddr = 2'd0; bus_a.write_data = '0;
    bus_b.digcs = 1'b0; bus_b.digwrite = 1'b0; bus_b.digaddr = 2'd0; bus_b.write_data = '0;

    // 1. reset state, then the digit walk with zeros
    repeat (3) @(negedge clk);
    chk("rst_dig", dig_a, 8'hFF);
    chk("rst_y", y_a, 8'hFF);
    chk("rst_busy", bus_a.busy, 1'b0);
    rst = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      e = ~(8'd1 << ((k / SCAN) % 8));
      chk("walk_dig", dig_a, e);
      chk("walk_y", y_a, 8'hC0);
    end

    // 2. hex mode
    bus_write(1'b0, 2'd0, 32'h1234ABCD);
    expect_display(32'h1234ABCD, 1'b0, 1'b0, 8'hFF, 8);
    busy_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus_a.busy) busy_seen++;
    end
    chk("hex_busy", busy_seen, 0);
    capture_round();

    // 3. decimal 12345678; hex buffer must persist until DONE
    for (int i = 0; i < 8; i++) old_codes[i] = model_code(32'h1234ABCD, 1'b0, 1'b0, 8'hFF, 8, i);
    bus_write(1'b0, 2'd1, 32'h0000FF01);
    bus_write(1'b0, 2'd0, 32'h00BC614E);
    expect_display(32'h00BC614E, 1'b1, 1'b0, 8'hFF, 8);
    wait_busy("busy_len_dec", 1'b1);
    capture_round();

    // 4. overflow to dashes, 8 and 4 digits
    bus_write(1'b0, 2'd0, 32'h05F5E100);
    expect_display(32'h05F5E100, 1'b1, 1'b0, 8'hFF, 8);
    wait_busy("busy_len_ovf", 1'b0);
    capture_round();
    bus_write(1'b1, 2'd1, 32'h0000FF01);
    bus_write(1'b1, 2'd0, 32'd10000);
    expect_display(32'd10000, 1'b1, 1'b0, 8'hFF, 4);
    repeat (80) @(negedge clk);
    sel_b = 1'b1;
    capture_round();
    sel_b = 1'b0;

    // 5. leading-zero blanking
    bus_write(1'b0, 2'd1, 32'h0000FF03);
    bus_write(1'b0, 2'd0, 32'd42);
    expect_display(32'd42, 1'b1, 1'b1, 8'hFF, 8);
    wait_busy("busy_len_42", 1'b0);
    capture_round();
    bus_write(1'b0, 2'd0, 32'd0);
    expect_display(32'd0, 1'b1, 1'b1, 8'hFF, 8);
    wait_busy("busy_len_0", 1'b0);
    capture_round();

    // 6. restart mid-conversion: 12345678 must never appear
    bus_write(1'b0, 2'd1, 32'h0000FF01);
    wait_busy("busy_len_ctrl", 1'b0);
    for (int i = 0; i < 8; i++) old_codes[i] = model_code(32'd0, 1'b1, 1'b0, 8'hFF, 8, i);
    bus_write(1'b0, 2'd0, 32'd12345678);
    repeat (10) begin
      @(negedge clk);
      check_hold();
    end
    bus_write(1'b0, 2'd0, 32'd7);
    expect_display(32'd7, 1'b1, 1'b0, 8'hFF, 8);
    wait_busy("busy_len_restart", 1'b1);
    capture_round();

    // blink on digit 0 with BLINK_DIV=2: lit in alternating pairs of rounds
    bus_write(1'b0, 2'd1, 32'h0001FF01);
    wait_busy("busy_len_blink", 1'b0);
    found = 0;
    prev  = dig_a;
    for (int k = 0; k < 100 && found == 0; k++) begin
      @(negedge clk);
      if (dig_a == 8'hFD && prev != 8'hFD) found = 1;
      else prev = dig_a;
    end
    chk("blink_sync", found, 1);
    lit0 = 0; lit7 = 0; y0_bad = 0; rounds0 = '0;
    for (int k = 0; k < 256; k++) begin
      if (k > 0) @(negedge clk);
      if (!dig_a[0]) begin
        lit0++;
        rounds0[k / 32] = 1'b1;
        if (y_a != 8'hF8) y0_bad++;
      end
      if (!dig_a[7]) lit7++;
    end
    chk("blink_d0_cnt", lit0, 16);
    chk("blink_d7_cnt", lit7, 32);
    chk("blink_d0_y", y0_bad, 0);
    chk("blink_pattern",
        (rounds0 == 8'h33 || rounds0 == 8'h66 || rounds0 == 8'hCC || rounds0 == 8'h99), 1'b1);

    // reset in the middle of a conversion
    bus_write(1'b0, 2'd0, 32'd12345678);
    repeat (5) @(negedge clk);
    chk("conv_busy", bus_a.busy, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", bus_a.busy, 1'b0);
    chk("midrst_dig", dig_a, 8'hFF);
    chk("midrst_y", y_a, 8'hFF);
    rst = 1'b1;
    expect_display(32'd0, 1'b0, 1'b0, 8'hFF, 8);
    capture_round();
    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
Parametrised memory-mapped seven-segment display controller. It replaces the fixed 8-digit hex-only tube driver on the CPU IO bus. It adds:
- configurable digit count and scan rate
- a decimal mode using a sequential binary-to-BCD converter
- leading-zero blanking, per-digit enable and per-digit blink

It is clocked by the CPU clock and written through the existing digcs/IOWrite path.

Parameters:
DIGITS, 8, number of digits driven (1..8).
SCAN_DIV, 20000, clk cycles each digit stays lit.
BLINK_DIV, 64, full scan rounds per blink half-period.

Ports:
clk  input  1  CPU clock.
rst  input  1  reset. Synchronous and active-low: registers initialise on the rising clk edge where rst=0.
digcs  input  1  chip select from the MemOrIO address decoder.
digwrite  input  1  IO write strobe. A write happens when digcs=1 and digwrite=1 at a rising edge.
digaddr  input  2  register select, taken from address[1:0].
write_data  input  32  write data from the CPU.
busy  output  1  decimal conversion in progress.
DIG  output  DIGITS  digit selects, active-low.
Y  output  8  segments, active-low. Y[7]=dp (always 1). Y[6:0]=g..a.

Behaviour:
- Reset (rst=0 at an edge):
  - VALUE=0.
  - MODE=0, LZB=0, ENABLE=all 1, BLINK=0.
  - scan index=0, scan and blink counters=0, blink phase=0.
  - display buffer=0, FSM=IDLE, busy=0.
  - DIG=all 1, Y=8'hFF while rst=0.
- Reset during CONV aborts the conversion; the buffer is cleared.
- Register map:
  - addr0 VALUE[31:0].
  - addr1 CTRL: bit0 MODE (0 hex, 1 decimal), bit1 LZB, bits[15:8] ENABLE, bits[23:16] BLINK.
  - addr2 and addr3: writes are ignored.
  - ENABLE/BLINK bits at index DIGITS or above are ignored.
- Hex mode: the display buffer nibble i equals VALUE[4i+3:4i]. It updates on the edge after the write (1-cycle latency). Bits above 4*DIGITS are not shown.
- Decimal mode FSM (IDLE -> CONV -> DONE -> IDLE):
  - Start: a write to addr0 or addr1 while the resulting MODE=1. The FSM enters CONV on the next edge, loading VALUE.
  - CONV: 32 cycles of shift-and-add-3 double-dabble, one bit per cycle. The BCD register is 40 bits.
  - DONE: 1 cycle. The BCD result is latched into the display buffer.
  - Overflow: if VALUE >= 10^DIGITS, the buffer is set to all DASH (Y=8'hBF) instead.
  - busy=1 throughout CONV and DONE, i.e. 33 cycles starting the edge after the write.
  - The buffer keeps its previous contents until DONE, so no intermediate digits are ever shown.
- Write during CONV/DONE: a new VALUE or CTRL write restarts CONV from cycle 0 with the new value, and busy stays high. If the write sets MODE=0, the conversion aborts, the FSM goes to IDLE and the hex path applies.
- Scan:
  - The counter counts 0..SCAN_DIV-1. At terminal count the index advances and wraps from DIGITS-1 to 0.
  - When the index wraps, the blink counter advances. When it reaches BLINK_DIV-1 it clears and the phase toggles.
- Digit i is lit (DIG[i]=0, other DIG bits=1) when all of the following hold:
  - i == index
  - ENABLE[i]=1
  - not (BLINK[i] and phase=1)
  - not LZB-blanked: LZB=1 blanks digit i only if i > 0 and every buffer digit from i up to DIGITS-1 is zero. Digit 0 is never LZB-blanked.
- When no digit is lit, DIG=all 1 and Y=8'hFF.
- Segment codes (active-low): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E, DASH BF.
- DIG and Y are registered and change together, one cycle after the index changes.

Test Plan:
1. Hold rst=0 for 3 cycles -> DIG=8'hFF, Y=8'hFF, busy=0. After release with SCAN_DIV=4 -> each digit in turn shows Y=8'hC0 for 4 cycles; DIG walks FE, FD, ..., 7F and wraps.
2. Hex mode, write addr0=0x1234ABCD -> while DIG=8'hFE, Y=8'hA1 ('d'); while DIG=8'h7F, Y=8'hF9 ('1'); busy stays 0.
3. Write CTRL=0x0000FF01, then VALUE=0x00BC614E (12345678):
   - busy=1 for exactly 33 cycles.
   - the old buffer is shown until DONE.
   - afterwards digit0 Y=8'h80 ('8') and digit7 Y=8'hF9 ('1').
4. Decimal mode, VALUE=0x05F5E100 (100000000) with DIGITS=8 -> every lit digit Y=8'hBF. Repeat with DIGITS=4 and VALUE=10000 -> all dashes.
5. CTRL=0x0000FF03 (decimal + LZB), VALUE=42:
   - only DIG[0] and DIG[1] ever go low.
   - digit0 Y=8'hA4, digit1 Y=8'h99.
   - VALUE=0 -> only digit0 lit, Y=8'hC0.
6. Decimal write of 12345678, then write VALUE=7 at CONV cycle 10:
   - busy remains high until 33 cycles after the second write.
   - final display is 7 (with LZB off, 00000007).
   - 12345678 is never displayed.
   - also check BLINK=0x01 with BLINK_DIV=2: digit0 is dark on alternate phases, other digits are unaffected.
   - also assert rst=0 mid-CONV: busy drops to 0 on that edge and the buffer clears.
